// File: rtl/spi_host.sv
// spi_host: valid/ready byte stream to a four-wire SPI (mode 0) + D/C bus.
// Every bus-facing output is registered. SCLK/CS_n/MOSI/DC are registered
// from the current state, so they trail the FSM by one cycle. tx_rdy_o and
// busy_o are registered from the next state, so they line up with the FSM.
// Optional build macro: SPI_HOST_RX_EN enables MISO capture on rx_vld_o/rx_data_o.
module spi_host #(
  parameter int CLK_DIV   = 3,
  parameter int SETUP_CYC = 2
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       tx_vld_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_dc_i,
  input  logic       tx_last_i,
  output logic       tx_rdy_o,
  output logic       busy_o,
  output logic       rx_vld_o,
  output logic [7:0] rx_data_o,
  output logic       spi_sclk_o,
  output logic       spi_mosi_o,
  output logic       spi_cs_n_o,
  output logic       spi_dc_o,
  input  logic       spi_miso_i
);

  localparam int MAX_CYC = (CLK_DIV > SETUP_CYC) ? CLK_DIV : SETUP_CYC;
  localparam int CW      = $clog2(MAX_CYC + 1);
  localparam logic [CW-1:0] DIV_LOAD   = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] SETUP_LOAD = CW'(SETUP_CYC - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_SETUP, ST_LOW, ST_HIGH, ST_WAIT, ST_HOLD
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    data_q;
  logic          dc_q, last_q;
  logic          accept, cnt_done;
  logic          cs_n_d, sclk_d, mosi_d, rdy_d, busy_d;

  assign accept   = tx_vld_i & tx_rdy_o;
  assign cnt_done = (cnt == '0);

  // Counter reload value for the state being entered.
  function automatic logic [CW-1:0] load_val(input state_t s);
    case (s)
      ST_SETUP, ST_HOLD: return SETUP_LOAD;
      ST_LOW, ST_HIGH:   return DIV_LOAD;
      default:           return '0;
    endcase
  endfunction

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic.
  // NOTE: default assignment first so no path leaves state_nxt unassigned (no latch).
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (accept) state_nxt = ST_SETUP;
      ST_SETUP: if (cnt_done) state_nxt = ST_LOW;
      ST_LOW:   if (cnt_done) state_nxt = ST_HIGH;
      ST_HIGH: begin
        if (cnt_done) begin
          if (idx != 3'd0) state_nxt = ST_LOW;
          else             state_nxt = last_q ? ST_HOLD : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (accept) state_nxt = (tx_dc_i == spi_dc_o) ? ST_LOW : ST_SETUP;
      end
      ST_HOLD:  if (cnt_done) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Byte latch, shared phase counter and bit index.
  // NOTE: the datapath is reset too, so a byte aborted by reset never leaks into the next one.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      data_q <= '0;
      dc_q   <= 1'b0;
      last_q <= 1'b0;
      cnt    <= '0;
      idx    <= 3'd7;
    end else begin
      if (accept) begin
        data_q <= tx_data_i;
        dc_q   <= tx_dc_i;
        last_q <= tx_last_i;
      end
      if (state_nxt != state) cnt <= load_val(state_nxt);
      else if (!cnt_done)     cnt <= cnt - CW'(1);
      if (state == ST_HIGH && state_nxt == ST_LOW) idx <= idx - 3'd1;
      else if (state != ST_LOW && state_nxt == ST_LOW) idx <= 3'd7;
    end
  end

  // Output decode; SETUP keeps SCLK where it was (low from IDLE, high from WAIT).
  always_comb begin
    cs_n_d = (state == ST_IDLE);
    sclk_d = spi_sclk_o;
    mosi_d = spi_mosi_o;
    case (state)
      ST_IDLE, ST_LOW, ST_HOLD: sclk_d = 1'b0;
      ST_HIGH, ST_WAIT:         sclk_d = 1'b1;
      default:                  sclk_d = spi_sclk_o;
    endcase
    if (state == ST_LOW) mosi_d = data_q[idx];
    rdy_d  = (state_nxt == ST_IDLE) || (state_nxt == ST_WAIT);
    busy_d = (state_nxt != ST_IDLE);
  end

  // Output registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      spi_cs_n_o <= 1'b1;
      spi_sclk_o <= 1'b0;
      spi_mosi_o <= 1'b0;
      spi_dc_o   <= 1'b0;
      tx_rdy_o   <= 1'b0;
      busy_o     <= 1'b0;
    end else begin
      spi_cs_n_o <= cs_n_d;
      spi_sclk_o <= sclk_d;
      spi_mosi_o <= mosi_d;
      spi_dc_o   <= dc_q;
      tx_rdy_o   <= rdy_d;
      busy_o     <= busy_d;
    end
  end

`ifdef SPI_HOST_RX_EN
  logic [7:0] rx_sh, rx_sh_nxt;
  logic       rx_sample, rx_done;

  // MISO is taken on the first HIGH cycle, i.e. the edge that raises SCLK.
  assign rx_sample = (state == ST_HIGH) && (cnt == DIV_LOAD);
  assign rx_done   = (state == ST_HIGH) && cnt_done && (idx == 3'd0);
  assign rx_sh_nxt = rx_sample ? {rx_sh[6:0], spi_miso_i} : rx_sh;

  // Receive shift register and completed-byte capture.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rx_sh     <= '0;
      rx_vld_o  <= 1'b0;
      rx_data_o <= '0;
    end else begin
      rx_sh    <= rx_sh_nxt;
      rx_vld_o <= rx_done;
      if (rx_done) rx_data_o <= rx_sh_nxt;
    end
  end
`else
  logic unused_miso;
  assign unused_miso = spi_miso_i;
  assign rx_vld_o    = 1'b0;
  assign rx_data_o   = '0;
`endif

endmodule

// File: tb/tb_spi_host.sv
// Directed bench for spi_host (CLK_DIV=3, SETUP_CYC=2), MISO looped to MOSI.
module tb_spi_host;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       tx_vld = 1'b0;
  logic [7:0] tx_data = '0;
  logic       tx_dc = 1'b0;
  logic       tx_last = 1'b0;
  logic       tx_rdy, busy, rx_vld;
  logic [7:0] rx_data;
  logic       sclk, mosi, cs_n, dc;

  int checks = 0;
  int errors = 0;

  spi_host #(.CLK_DIV(3), .SETUP_CYC(2)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .tx_vld_i(tx_vld), .tx_data_i(tx_data), .tx_dc_i(tx_dc), .tx_last_i(tx_last),
    .tx_rdy_o(tx_rdy), .busy_o(busy), .rx_vld_o(rx_vld), .rx_data_o(rx_data),
    .spi_sclk_o(sclk), .spi_mosi_o(mosi), .spi_cs_n_o(cs_n), .spi_dc_o(dc),
    .spi_miso_i(mosi)
  );

  always #5 clk = ~clk;

  // Bus monitor, sampled on the falling clock edge.
  int          cyc = 0, rise_cnt = 0, cs_low_cnt = 0, wait_cnt = 0;
  int          dc_bad_cnt = 0, rx_cnt = 0, accept_cnt = 0;
  int          dc_rise_cyc = 0, dc_gap = -1;
  logic        dc_pending = 1'b0, dc_rise_sclk = 1'b0;
  logic        sclk_p = 1'b0, dc_p = 1'b0, cs_p = 1'b1;
  logic [31:0] mosi_sh = '0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (sclk && !sclk_p) begin
      rise_cnt = rise_cnt + 1;
      mosi_sh  = {mosi_sh[30:0], mosi};
    end
    if (!sclk && sclk_p && dc_pending) begin
      dc_gap     = cyc - dc_rise_cyc;
      dc_pending = 1'b0;
    end
    if (dc && !dc_p) begin
      dc_rise_cyc  = cyc;
      dc_rise_sclk = sclk;
      dc_pending   = 1'b1;
    end
    if ((dc !== dc_p) && !cs_p && !sclk) dc_bad_cnt = dc_bad_cnt + 1;
    if (!cs_n) cs_low_cnt = cs_low_cnt + 1;
    if (busy && tx_rdy) wait_cnt = wait_cnt + 1;
    if (rx_vld) rx_cnt = rx_cnt + 1;
    if (tx_vld && tx_rdy) accept_cnt = accept_cnt + 1;
    sclk_p = sclk;
    dc_p   = dc;
    cs_p   = cs_n;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present a byte and hold it until the DUT accepts it.
  task automatic send(input logic [7:0] d, input logic d_c, input logic last);
    int n = 0;
    @(negedge clk);
    tx_vld = 1'b1; tx_data = d; tx_dc = d_c; tx_last = last;
    while (tx_rdy !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("accept_in_time", 32'(n < 1000), 32'd1);
    @(posedge clk);
    #1 tx_vld = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("idle_in_time", 32'(n < 2000), 32'd1);
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cs_n"},  32'(cs_n),    32'd1);
    check({tag, "_sclk"},  32'(sclk),    32'd0);
    check({tag, "_mosi"},  32'(mosi),    32'd0);
    check({tag, "_dc"},    32'(dc),      32'd0);
    check({tag, "_rdy"},   32'(tx_rdy),  32'd0);
    check({tag, "_busy"},  32'(busy),    32'd0);
    check({tag, "_rxvld"}, 32'(rx_vld),  32'd0);
    check({tag, "_rxdat"}, 32'(rx_data), 32'd0);
  endtask

  int r0, c0, w0, x0, a0, b0, n;

  initial begin
    // Power-on reset.
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("por");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1 check("por_rdy_release", 32'(tx_rdy), 32'd0);
    @(posedge clk);
    #1 check("por_rdy_first_clk", 32'(tx_rdy), 32'd1);
    check("por_cs_idle", 32'(cs_n), 32'd1);

    // Single byte 0x2C, command, last.
    r0 = rise_cnt; c0 = cs_low_cnt; w0 = wait_cnt;
    send(8'h2C, 1'b0, 1'b1);
    wait_idle();
    check("single_rises", 32'(rise_cnt - r0), 32'd8);
    check("single_mosi", 32'(mosi_sh[7:0]), 32'h2C);
    check("single_cs_low", 32'(cs_low_cnt - c0), 32'd52);
    check("single_rdy_low", 32'(wait_cnt - w0), 32'd0);
    check("single_cs_end", 32'(cs_n), 32'd1);

    // Stream: 0x2C cmd, 0xFF/0x00/0xA5 data.
    r0 = rise_cnt; c0 = cs_low_cnt; x0 = dc_bad_cnt; a0 = accept_cnt;
    send(8'h2C, 1'b0, 1'b0);
    send(8'hFF, 1'b1, 1'b0);
    send(8'h00, 1'b1, 1'b0);
    send(8'hA5, 1'b1, 1'b1);
    wait_idle();
    check("stream_rises", 32'(rise_cnt - r0), 32'd32);
    check("stream_mosi", mosi_sh, 32'h2CFF00A5);
    check("stream_cs_low", 32'(cs_low_cnt - c0), 32'd201);
    check("stream_dc_rise_sclk", 32'(dc_rise_sclk), 32'd1);
    check("stream_dc_setup", 32'(dc_gap), 32'd2);
    check("stream_dc_sclk_low", 32'(dc_bad_cnt - x0), 32'd0);
    check("stream_accepts", 32'(accept_cnt - a0), 32'd4);

    // Loopback receive of 0xA5.
    b0 = rx_cnt;
    send(8'hA5, 1'b1, 1'b1);
    wait_idle();
`ifdef SPI_HOST_RX_EN
    check("rx_pulses", 32'(rx_cnt - b0), 32'd1);
    check("rx_data", 32'(rx_data), 32'hA5);
`else
    check("rx_pulses", 32'(rx_cnt - b0), 32'd0);
    check("rx_data", 32'(rx_data), 32'h00);
`endif

    // Valid held high mid-byte: not taken until WAIT, then sent intact.
    r0 = rise_cnt; c0 = cs_low_cnt; a0 = accept_cnt;
    send(8'h11, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    tx_vld = 1'b1; tx_data = 8'h3C; tx_dc = 1'b0; tx_last = 1'b1;
    #1 check("hold_rdy_midbyte", 32'(tx_rdy), 32'd0);
    send(8'h3C, 1'b0, 1'b1);
    wait_idle();
    check("hold_rises", 32'(rise_cnt - r0), 32'd16);
    check("hold_mosi", 32'(mosi_sh[15:0]), 32'h113C);
    check("hold_cs_low", 32'(cs_low_cnt - c0), 32'd101);
    check("hold_accepts", 32'(accept_cnt - a0), 32'd2);

    // Reset asserted during bit 4 of 0x5A.
    r0 = rise_cnt;
    send(8'h5A, 1'b0, 1'b1);
    n = 0;
    while ((rise_cnt - r0) < 3 && n < 500) begin
      @(negedge clk);
      #1 n++;
    end
    check("midrst_reach_bit5", 32'(n < 500), 32'd1);
    repeat (3) @(negedge clk);
    #1 check("midrst_busy", 32'(busy), 32'd1);
    check("midrst_bit4_low", 32'(sclk), 32'd0);
    check("midrst_bit4_mosi", 32'(mosi), 32'd1);
    rst_n = 1'b0;
    #1 check_reset_outputs("midrst");
    r0 = rise_cnt;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1 check("midrst_rdy_release", 32'(tx_rdy), 32'd0);
    @(posedge clk);
    #1 check("midrst_rdy_first_clk", 32'(tx_rdy), 32'd1);
    repeat (4) @(negedge clk);
    #1 check("midrst_no_edges", 32'(rise_cnt - r0), 32'd0);
    check("midrst_cs_idle", 32'(cs_n), 32'd1);

    // Clean transfer after the aborted byte.
    r0 = rise_cnt; c0 = cs_low_cnt;
    send(8'hC3, 1'b1, 1'b1);
    wait_idle();
    check("post_rises", 32'(rise_cnt - r0), 32'd8);
    check("post_mosi", 32'(mosi_sh[7:0]), 32'hC3);
    check("post_cs_low", 32'(cs_low_cnt - c0), 32'd52);
`ifdef SPI_HOST_RX_EN
    check("post_rx_data", 32'(rx_data), 32'hC3);
`else
    check("post_rx_data", 32'(rx_data), 32'h00);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
